// File: rtl/pixie_video_gen.sv
// pixie_video_gen: raster timing generator and framebuffer pixel serialiser.
// Latency: every video/sync/blank/frame_start output trails the counter state by 3 clocks.
// Backpressure: none; the framebuffer must return fb_data exactly one clock after fb_read_en.
//
// Ports:
//   clk, reset              pixel clock, synchronous active-high reset
//   enable                  0 forces video to 0 (timing and fetches continue)
//   page_sel                requested page, sampled at frame start
//   fb_read_en/fb_addr      one-clock read strobe and {page, byte pointer} address
//   fb_data                 read data, valid the clock after fb_read_en
//   video, video_de         pixel code and active-area enable
//   hsync/vsync/csync       active-high syncs, csync = hsync ^ vsync
//   hblank/vblank           inverse of horizontal/vertical active
//   frame_start             one-clock pulse aligned with line 0, pixel 0
//   page_active             page currently being displayed
module pixie_video_gen #(
  parameter int H_ACTIVE  = 64,
  parameter int H_TOTAL   = 112,
  parameter int HS_START  = 80,
  parameter int HS_WIDTH  = 12,
  parameter int V_ACTIVE  = 128,
  parameter int V_TOTAL   = 262,
  parameter int VS_START  = 182,
  parameter int VS_HEIGHT = 16,
  parameter int BPP       = 1,
  parameter int PIX_REP   = 1,
  parameter int V_REP     = 1,
  parameter int ADDR_W    = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              page_sel,
  output logic              fb_read_en,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_data,
  output logic [BPP-1:0]    video,
  output logic              video_de,
  output logic              hsync,
  output logic              vsync,
  output logic              csync,
  output logic              hblank,
  output logic              vblank,
  output logic              frame_start,
  output logic              page_active
);

  localparam int HW     = $clog2(H_TOTAL + 1);
  localparam int VW     = $clog2(V_TOTAL + 1);
  localparam int PW     = ADDR_W - 1;
  localparam int PPB_LG = (BPP == 2) ? 2 : 3;   // log2 of pixels per byte

  localparam logic [1:0]    P_LAST     = 2'(PIX_REP - 1);
  localparam logic [1:0]    R_LAST     = 2'(V_REP - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_B       = HW'(HS_START);
  localparam logic [HW-1:0] HS_E       = HW'(HS_START + HS_WIDTH);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE * V_REP);
  localparam logic [VW-1:0] VS_B       = VW'(VS_START);
  localparam logic [VW-1:0] VS_E       = VW'(VS_START + VS_HEIGHT);

  // Per-slot control bits carried down the pipeline next to the fetch.
  typedef struct packed {
    logic de;
    logic hb;
    logic vb;
    logic hs;
    logic vs;
    logic fs;
    logic adv;   // first clock of a new pixel slot
    logic pg;    // page in use for this frame
  } ctl_t;

  // Counter state
  logic [1:0]    p_q, p_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [1:0]    r_q, r_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] line_start_q, line_start_d;
  logic          page_fetch_q, page_fetch_d;

  // Stage 1: fetch request and control
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  ctl_t              ctl1_q, ctl1_d;

  // Stage 2: read data arrives
  logic ld_q, ld_d;
  ctl_t ctl2_q, ctl2_d;

  // Stage 3: output registers
  logic [7:0]     sr_q, sr_d;
  logic [BPP-1:0] video_q, video_d;
  logic           de_q, de_d;
  logic           hs_q, hs_d;
  logic           vs_q, vs_d;
  logic           cs_q, cs_d;
  logic           hb_q, hb_d;
  logic           vb_q, vb_d;
  logic           fs_q, fs_d;
  logic           pa_q, pa_d;

  // Combinational helpers
  logic p_end, h_wrap, v_wrap;
  logic h_act, v_act, act, first, page_now, fetch;
  ctl_t ctl0;

  always_comb begin
    p_end  = (p_q == P_LAST);
    h_wrap = p_end && (h_q == H_LAST);
    v_wrap = h_wrap && (v_q == V_LAST);

    p_d = p_end ? 2'd0 : p_q + 2'd1;
    h_d = h_q;
    if (p_end) h_d = (h_q == H_LAST) ? '0 : h_q + HW'(1);
    v_d = v_q;
    r_d = r_q;
    if (h_wrap) begin
      v_d = v_wrap ? '0 : v_q + VW'(1);
      r_d = (v_wrap || r_q == R_LAST) ? 2'd0 : r_q + 2'd1;
    end

    h_act = (h_q < H_ACT);
    v_act = (v_q < V_ACT);
    act   = h_act && v_act;
    first = (p_q == 2'd0) && (h_q == '0) && (v_q == '0);

    // page_sel is looked at only on the very first slot of a frame, so the
    // whole frame (fetch address and displayed page) uses one page.
    page_now     = first ? page_sel : page_fetch_q;
    page_fetch_d = page_now;

    fetch = act && (p_q == 2'd0) && (h_q[PPB_LG-1:0] == '0);

    ptr_d        = ptr_q;
    line_start_d = line_start_q;
    if (fetch) ptr_d = ptr_q + PW'(1);
    // Last clock of an active line: no fetch happens here, so ptr_q is
    // already the start of the following framebuffer line.
    if (act && p_end && (h_q == H_ACT_LAST)) begin
      if (r_q != R_LAST) ptr_d = line_start_q;
      else               line_start_d = ptr_q;
    end
    if (v_wrap) begin
      ptr_d        = '0;
      line_start_d = '0;
    end

    rd_d   = fetch;
    addr_d = fetch ? {page_now, ptr_q} : addr_q;

    ctl0.de  = act;
    ctl0.hb  = !h_act;
    ctl0.vb  = !v_act;
    ctl0.hs  = (h_q >= HS_B) && (h_q < HS_E);
    ctl0.vs  = (v_q >= VS_B) && (v_q < VS_E);
    ctl0.fs  = first;
    ctl0.adv = (p_q == 2'd0);
    ctl0.pg  = page_now;
    ctl1_d   = ctl0;

    ld_d   = rd_q;
    ctl2_d = ctl1_q;

    // The top BPP bits of sr always hold the pixel currently on screen.
    sr_d = sr_q;
    if (ld_q)            sr_d = fb_data;
    else if (ctl2_q.adv) sr_d = sr_q << BPP;

    video_d = (ctl2_q.de && enable) ? sr_d[7 -: BPP] : '0;
    de_d    = ctl2_q.de;
    hs_d    = ctl2_q.hs;
    vs_d    = ctl2_q.vs;
    cs_d    = ctl2_q.hs ^ ctl2_q.vs;
    hb_d    = ctl2_q.hb;
    vb_d    = ctl2_q.vb;
    fs_d    = ctl2_q.fs;
    pa_d    = ctl2_q.fs ? ctl2_q.pg : pa_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q          <= '0;
      h_q          <= '0;
      v_q          <= '0;
      r_q          <= '0;
      ptr_q        <= '0;
      line_start_q <= '0;
      page_fetch_q <= 1'b0;
      rd_q         <= 1'b0;
      addr_q       <= '0;
      ctl1_q       <= '0;
      ld_q         <= 1'b0;
      ctl2_q       <= '0;
      sr_q         <= '0;
      video_q      <= '0;
      de_q         <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      cs_q         <= 1'b0;
      hb_q         <= 1'b0;
      vb_q         <= 1'b0;
      fs_q         <= 1'b0;
      pa_q         <= 1'b0;
    end else begin
      p_q          <= p_d;
      h_q          <= h_d;
      v_q          <= v_d;
      r_q          <= r_d;
      ptr_q        <= ptr_d;
      line_start_q <= line_start_d;
      page_fetch_q <= page_fetch_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
      ctl1_q       <= ctl1_d;
      ld_q         <= ld_d;
      ctl2_q       <= ctl2_d;
      sr_q         <= sr_d;
      video_q      <= video_d;
      de_q         <= de_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      cs_q         <= cs_d;
      hb_q         <= hb_d;
      vb_q         <= vb_d;
      fs_q         <= fs_d;
      pa_q         <= pa_d;
    end
  end

  assign fb_read_en  = rd_q;
  assign fb_addr     = addr_q;
  assign video       = video_q;
  assign video_de    = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign csync       = cs_q;
  assign hblank      = hb_q;
  assign vblank      = vb_q;
  assign frame_start = fs_q;
  assign page_active = pa_q;

endmodule

// File: tb/tb_pixie_video_gen.sv
// tb_pixie_video_gen: directed checks of three pixie_video_gen configurations.
// Latency: outputs expected 3 clocks after the counter state they describe.
// Backpressure: framebuffer models answer every read one clock later.
module tb_pixie_video_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset    = 1'b1;
  logic enable   = 1'b1;
  logic page_sel = 1'b0;
  logic en_bc    = 1'b1;
  logic pg_bc    = 1'b0;

  int total = 0;
  int bad   = 0;

  // Instance A: default parameters
  logic        a_rd, a_de, a_hs, a_vs, a_cs, a_hb, a_vb, a_fs, a_pa;
  logic [10:0] a_addr;
  logic [7:0]  a_dat;
  logic [0:0]  a_video;

  // Instance B: 2 bpp, each pixel held 2 clocks
  logic        b_rd, b_de, b_hs, b_vs, b_cs, b_hb, b_vb, b_fs, b_pa;
  logic [10:0] b_addr;
  logic [7:0]  b_dat;
  logic [1:0]  b_video;

  // Instance C: each framebuffer line shown twice
  logic        c_rd, c_de, c_hs, c_vs, c_cs, c_hb, c_vb, c_fs, c_pa;
  logic [10:0] c_addr;
  logic [7:0]  c_dat;
  logic [0:0]  c_video;

  pixie_video_gen u_a (
    .clk(clk), .reset(reset), .enable(enable), .page_sel(page_sel),
    .fb_read_en(a_rd), .fb_addr(a_addr), .fb_data(a_dat),
    .video(a_video), .video_de(a_de), .hsync(a_hs), .vsync(a_vs), .csync(a_cs),
    .hblank(a_hb), .vblank(a_vb), .frame_start(a_fs), .page_active(a_pa)
  );

  pixie_video_gen #(.BPP(2), .PIX_REP(2)) u_b (
    .clk(clk), .reset(reset), .enable(en_bc), .page_sel(pg_bc),
    .fb_read_en(b_rd), .fb_addr(b_addr), .fb_data(b_dat),
    .video(b_video), .video_de(b_de), .hsync(b_hs), .vsync(b_vs), .csync(b_cs),
    .hblank(b_hb), .vblank(b_vb), .frame_start(b_fs), .page_active(b_pa)
  );

  pixie_video_gen #(.V_REP(2), .V_ACTIVE(64)) u_c (
    .clk(clk), .reset(reset), .enable(en_bc), .page_sel(pg_bc),
    .fb_read_en(c_rd), .fb_addr(c_addr), .fb_data(c_dat),
    .video(c_video), .video_de(c_de), .hsync(c_hs), .vsync(c_vs), .csync(c_cs),
    .hblank(c_hb), .vblank(c_vb), .frame_start(c_fs), .page_active(c_pa)
  );

  function automatic logic [7:0] fb_byte_a(input logic [10:0] a);
    return (a[9:0] == 10'd0) ? 8'hA5 : (a[7:0] ^ 8'h3C);
  endfunction

  function automatic logic [7:0] fb_byte_b(input logic [10:0] a);
    return (a[9:0] == 10'd0) ? 8'h1B : 8'hE4;
  endfunction

  // One-clock-latency framebuffers
  always @(posedge clk) begin
    if (a_rd) a_dat <= fb_byte_a(a_addr);
    if (b_rd) b_dat <= fb_byte_b(b_addr);
    if (c_rd) c_dat <= fb_byte_a(c_addr);
  end

  // Returns at the falling edge just after the reset clock (cycle c0, counters at 0).
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] fsv;
    page_sel = 1'b0;
    enable   = 1'b1;
    repeat (5) @(negedge clk);
    do_reset();
    total++;
    if ({a_video, a_de, a_hs, a_vs, a_cs, a_hb, a_vb, a_fs, a_pa, a_rd, a_addr} !== 21'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h required=0",
               {a_video, a_de, a_hs, a_vs, a_cs, a_hb, a_vb, a_fs, a_pa, a_rd, a_addr});
    end
    fsv[0] = a_fs;
    @(negedge clk);
    total++;
    if ({a_rd, a_addr} !== {1'b1, 11'd0}) begin
      bad++;
      $display("FAIL reset_first_fetch got rd=%b addr=%h required rd=1 addr=000", a_rd, a_addr);
    end
    fsv[1] = a_fs;
    @(negedge clk);
    fsv[2] = a_fs;
    @(negedge clk);
    fsv[3] = a_fs;
    total++;
    if (fsv !== 4'b1000) begin
      bad++;
      $display("FAIL reset_frame_start_delay got=%b required=1000", fsv);
    end
    total++;
    if ({a_hb, a_vb, a_de} !== 3'b001) begin
      bad++;
      $display("FAIL reset_first_active got hb,vb,de=%b required=001", {a_hb, a_vb, a_de});
    end
  endtask

  task automatic test_pixels();
    logic [7:0] pix;
    int de_cnt;
    enable = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    pix = '0;
    de_cnt = 0;
    for (int i = 0; i < 112; i++) begin
      if (i < 8) pix = {pix[6:0], a_video[0]};
      if (a_de) de_cnt++;
      @(negedge clk);
    end
    total++;
    if (pix !== 8'hA5) begin
      bad++;
      $display("FAIL pixel_order got=%h required=a5", pix);
    end
    total++;
    if (de_cnt != 64) begin
      bad++;
      $display("FAIL line_de_width got=%0d required=64", de_cnt);
    end
  endtask

  task automatic test_enable();
    logic [7:0] pix;
    int de_cnt;
    enable = 1'b0;
    do_reset();
    @(negedge clk);
    total++;
    if (a_rd !== 1'b1) begin
      bad++;
      $display("FAIL enable_fetch got rd=%b required=1", a_rd);
    end
    repeat (2) @(negedge clk);
    pix = '0;
    de_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      pix = {pix[6:0], a_video[0]};
      if (a_de) de_cnt++;
      @(negedge clk);
    end
    total++;
    if ({pix, 4'(de_cnt)} !== {8'h00, 4'd8}) begin
      bad++;
      $display("FAIL enable_gating got video=%h de_cnt=%0d required video=00 de_cnt=8", pix, de_cnt);
    end
    enable = 1'b1;
  endtask

  task automatic test_bpp2();
    logic [17:0] rdv;
    logic [15:0] vv;
    do_reset();
    rdv = '0;
    vv  = '0;
    for (int i = 0; i < 18; i++) begin
      rdv[i] = b_rd;
      if (i >= 3 && i < 11) vv = {vv[13:0], b_video};
      @(negedge clk);
    end
    total++;
    if (vv !== 16'h05AF) begin
      bad++;
      $display("FAIL bpp2_pixels got=%h required=05af", vv);
    end
    total++;
    if (rdv !== 18'h20202) begin
      bad++;
      $display("FAIL bpp2_fetch_spacing got=%h required=20202", rdv);
    end
  endtask

  task automatic test_vrep();
    int k;
    logic [10:0] exp_addr;
    do_reset();
    k = 0;
    for (int cyc = 0; cyc < 336; cyc++) begin
      if (c_rd) begin
        exp_addr = 11'(((k / 8) / 2) * 8 + (k % 8));
        total++;
        if (c_addr !== exp_addr) begin
          bad++;
          $display("FAIL vrep_addr read=%0d got=%h required=%h", k, c_addr, exp_addr);
        end
        k++;
      end
      @(negedge clk);
    end
    total++;
    if (k != 24) begin
      bad++;
      $display("FAIL vrep_read_count got=%0d required=24", k);
    end
  endtask

  task automatic test_frames();
    int hs_rise, hs_high, hs_first, vs_high, fs_cnt, fs_c0, fs_c1;
    int rd_cnt, rd_f0, addr_err, per_err, last_rise, a_de_cnt, c_de_cnt, c_de_rise;
    logic prev_hs, prev_cde, pa_mid, pa_pre, pa_post;
    logic [10:0] exp_addr;
    hs_rise = 0; hs_high = 0; hs_first = -1; vs_high = 0; fs_cnt = 0; fs_c0 = -1; fs_c1 = -1;
    rd_cnt = 0; rd_f0 = 0; addr_err = 0; per_err = 0; last_rise = -1;
    a_de_cnt = 0; c_de_cnt = 0; c_de_rise = 0;
    prev_hs = 1'b0; prev_cde = 1'b0; pa_mid = 1'bx; pa_pre = 1'bx; pa_post = 1'bx;
    page_sel = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 2 * 29344; cyc++) begin
      if (cyc == 10000) page_sel = 1'b1;
      if (a_hs && !prev_hs) begin
        if (last_rise >= 0 && cyc - last_rise != 112) per_err++;
        if (hs_first < 0) hs_first = cyc;
        last_rise = cyc;
        hs_rise++;
      end
      if (a_hs) hs_high++;
      if (a_vs) vs_high++;
      if (a_de) a_de_cnt++;
      if (a_fs) begin
        fs_cnt++;
        if (fs_c0 < 0) fs_c0 = cyc;
        else fs_c1 = cyc;
      end
      if (a_rd) begin
        exp_addr = {(rd_cnt >= 1024) ? 1'b1 : 1'b0, 10'(rd_cnt % 1024)};
        if (a_addr !== exp_addr) begin
          if (addr_err == 0)
            $display("first bad read index=%0d got=%h expected=%h", rd_cnt, a_addr, exp_addr);
          addr_err++;
        end
        rd_cnt++;
        if (cyc < 29344) rd_f0++;
      end
      if (cyc < 29344) begin
        if (c_de) c_de_cnt++;
        if (c_de && !prev_cde) c_de_rise++;
      end
      if (cyc == 20000) pa_mid = a_pa;
      if (cyc == 29346) pa_pre = a_pa;
      if (cyc == 29348) pa_post = a_pa;
      prev_hs  = a_hs;
      prev_cde = c_de;
      @(negedge clk);
    end
    page_sel = 1'b0;

    total++; if (hs_rise != 524) begin bad++; $display("FAIL hsync_pulses got=%0d required=524", hs_rise); end
    total++; if (hs_high != 524 * 12) begin bad++; $display("FAIL hsync_width_total got=%0d required=%0d", hs_high, 524 * 12); end
    total++; if (per_err != 0) begin bad++; $display("FAIL hsync_period bad_periods=%0d required=0", per_err); end
    total++; if (hs_first != 83) begin bad++; $display("FAIL hsync_first got=%0d required=83", hs_first); end
    total++; if (vs_high != 2 * 1792) begin bad++; $display("FAIL vsync_width_total got=%0d required=3584", vs_high); end
    total++; if (fs_cnt != 2) begin bad++; $display("FAIL frame_start_count got=%0d required=2", fs_cnt); end
    total++; if (fs_c0 != 3) begin bad++; $display("FAIL frame_start_first got=%0d required=3", fs_c0); end
    total++; if (fs_c1 - fs_c0 != 29344) begin bad++; $display("FAIL frame_period got=%0d required=29344", fs_c1 - fs_c0); end
    total++; if (rd_f0 != 1024) begin bad++; $display("FAIL reads_per_frame got=%0d required=1024", rd_f0); end
    total++; if (rd_cnt != 2048) begin bad++; $display("FAIL reads_two_frames got=%0d required=2048", rd_cnt); end
    total++; if (addr_err != 0) begin bad++; $display("FAIL addr_sweep bad_reads=%0d required=0", addr_err); end
    total++; if (a_de_cnt != 2 * 8192) begin bad++; $display("FAIL de_total got=%0d required=16384", a_de_cnt); end
    total++; if (pa_mid !== 1'b0) begin bad++; $display("FAIL page_mid_frame got=%b required=0", pa_mid); end
    total++; if (pa_pre !== 1'b0) begin bad++; $display("FAIL page_before_frame got=%b required=0", pa_pre); end
    total++; if (pa_post !== 1'b1) begin bad++; $display("FAIL page_after_frame got=%b required=1", pa_post); end
    total++; if (c_de_cnt != 8192) begin bad++; $display("FAIL vrep_de_total got=%0d required=8192", c_de_cnt); end
    total++; if (c_de_rise != 128) begin bad++; $display("FAIL vrep_active_lines got=%0d required=128", c_de_rise); end
  endtask

  task automatic test_midline_reset();
    page_sel = 1'b0;
    repeat (50) @(negedge clk);
    do_reset();
    total++;
    if ({a_video, a_de, a_hs, a_vs, a_cs, a_hb, a_vb, a_fs, a_pa, a_rd, a_addr} !== 21'd0) begin
      bad++;
      $display("FAIL midline_reset_outputs got=%h required=0",
               {a_video, a_de, a_hs, a_vs, a_cs, a_hb, a_vb, a_fs, a_pa, a_rd, a_addr});
    end
    @(negedge clk);
    total++;
    if ({a_rd, a_addr} !== {1'b1, 11'd0}) begin
      bad++;
      $display("FAIL midline_first_fetch got rd=%b addr=%h required rd=1 addr=000", a_rd, a_addr);
    end
    repeat (2) @(negedge clk);
    total++;
    if ({a_de, a_video, a_fs} !== 3'b111) begin
      bad++;
      $display("FAIL midline_restart got de,video,fs=%b required=111", {a_de, a_video, a_fs});
    end
  endtask

  initial begin
    test_reset();
    test_pixels();
    test_enable();
    test_bpp2();
    test_vrep();
    test_frames();
    test_midline_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
